// File: rtl/arm_pkg.sv
// Shared definitions for the fetch/decode front end: opcodes, instruction
// field positions, condition codes and the fetch state encoding.
package arm_pkg;

  localparam logic [6:0] OP_NOP   = 7'h00;
  localparam logic [6:0] OP_HLT   = 7'h01;
  localparam logic [6:0] OP_ADD   = 7'h08;
  localparam logic [6:0] OP_SUB   = 7'h09;
  localparam logic [6:0] OP_AND   = 7'h0A;
  localparam logic [6:0] OP_ORR   = 7'h0B;
  localparam logic [6:0] OP_EOR   = 7'h0C;
  localparam logic [6:0] OP_MOV_R = 7'h0D;
  localparam logic [6:0] OP_CMP   = 7'h0E;
  localparam logic [6:0] OP_MOV_I = 7'h10;

  localparam int COND_MSB = 31;
  localparam int COND_LSB = 28;
  localparam int OPC_MSB  = 27;
  localparam int OPC_LSB  = 21;
  localparam int SETF_BIT = 20;
  localparam int RN_MSB   = 19;
  localparam int RN_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 12;
  localparam int RS_MSB   = 11;
  localparam int RS_LSB   = 8;
  localparam int SH_MSB   = 7;
  localparam int SH_LSB   = 6;
  localparam int RM_MSB   = 3;
  localparam int RM_LSB   = 0;
  localparam int IMM_MSB  = 11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Bit positions inside the 4-bit NZCV status vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_WAIT  = 2'd2,
    FS_VALID = 2'd3
  } fetch_state_e;

  function automatic logic is_hlt(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB] == OP_HLT;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational field extraction and condition evaluation for the word held
// in the instruction register.
module instr_decode
  import arm_pkg::*;
(
  input  logic [31:0] ir_i,
  input  logic [3:0]  nzcv_i,
  output logic [6:0]  opcode_o,
  output logic        set_flags_o,
  output logic [3:0]  rn_o,
  output logic [3:0]  rd_o,
  output logic [3:0]  rs_o,
  output logic [3:0]  rm_o,
  output logic [1:0]  shift_op_o,
  output logic [31:0] imm12_o,
  output logic        cond_pass_o
);

  logic unused_bits;

  assign opcode_o    = ir_i[OPC_MSB:OPC_LSB];
  assign set_flags_o = ir_i[SETF_BIT];
  assign rn_o        = ir_i[RN_MSB:RN_LSB];
  assign rd_o        = ir_i[RD_MSB:RD_LSB];
  assign rs_o        = ir_i[RS_MSB:RS_LSB];
  assign rm_o        = ir_i[RM_MSB:RM_LSB];
  assign shift_op_o  = ir_i[SH_MSB:SH_LSB];
  assign imm12_o     = {20'h0, ir_i[IMM_MSB:0]};

  // Bits [5:4] carry no field in this encoding and no condition looks at C.
  assign unused_bits = ^{ir_i[5:4], nzcv_i[FLAG_C]};

  always_comb begin
    // NOTE: default first so every path assigns cond_pass_o and no latch is inferred.
    cond_pass_o = 1'b0;
    case (ir_i[COND_MSB:COND_LSB])
      COND_EQ: cond_pass_o = nzcv_i[FLAG_Z];
      COND_NE: cond_pass_o = !nzcv_i[FLAG_Z];
      COND_GE: cond_pass_o = (nzcv_i[FLAG_N] == nzcv_i[FLAG_V]);
      COND_LT: cond_pass_o = (nzcv_i[FLAG_N] != nzcv_i[FLAG_V]);
      COND_AL: cond_pass_o = 1'b1;
      default: cond_pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register and a one-outstanding-read
// handshake to instruction memory, with redirect/squash and halt handling.
module fetch_unit
  import arm_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              load_pc,
  input  logic              clear_pc,
  input  logic [31:0]       pc_in,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  input  logic [3:0]        status_nzcv,
  output logic [31:0]       pc,
  output logic              ir_valid,
  output logic [31:0]       ir,
  output logic [6:0]        opcode,
  output logic              set_flags,
  output logic [3:0]        rn,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rm,
  output logic [1:0]        shift_op,
  output logic [31:0]       imm12,
  output logic              cond_pass,
  output logic              halted,
  output logic              busy
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  ir_q;
  logic         ir_valid_q;
  logic         halted_q;
  logic         pend_q;
  logic         squash_q;
  logic         mem_rd_en_q;
  logic         busy_q;

  logic         redirect;
  logic [31:0]  redirect_pc;
  logic [31:0]  pc_inc;
  logic         fetch_pending;
  logic         unused_pc_in;

  assign redirect      = clear_pc | load_pc;
  assign redirect_pc   = clear_pc ? RESET_PC : {pc_in[31:2], 2'b00};
  assign pc_inc        = pc_q + 32'd4;
  assign fetch_pending = fetch_req | pend_q;
  assign unused_pc_in  = ^pc_in[1:0];

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FS_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= 32'h0;
      ir_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
      pend_q      <= 1'b0;
      squash_q    <= 1'b0;
      mem_rd_en_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (redirect) pc_q <= redirect_pc;
      if (clear_pc) halted_q <= 1'b0;

      case (state_q)
        FS_IDLE, FS_VALID: begin
          // A redirect takes this cycle; a coincident request waits for the new PC.
          if (redirect) begin
            pend_q <= pend_q | fetch_req;
          end else if (fetch_pending && !halted_q) begin
            state_q     <= FS_REQ;
            pend_q      <= 1'b0;
            ir_valid_q  <= 1'b0;
            mem_rd_en_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        FS_REQ, FS_WAIT: begin
          mem_rd_en_q <= 1'b0;
          if (fetch_req) pend_q <= 1'b1;
          if (mem_rvalid) begin
            squash_q <= 1'b0;
            busy_q   <= 1'b0;
            if (squash_q || redirect) begin
              state_q <= FS_IDLE;
            end else begin
              state_q    <= FS_VALID;
              ir_q       <= mem_rdata;
              pc_q       <= pc_inc;
              ir_valid_q <= 1'b1;
              if (is_hlt(mem_rdata)) halted_q <= 1'b1;
            end
          end else begin
            state_q <= FS_WAIT;
            if (redirect) squash_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= FS_IDLE;
          mem_rd_en_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign halted    = halted_q;
  assign mem_rd_en = mem_rd_en_q;
  assign busy      = busy_q;
  assign mem_addr  = pc_q[ADDR_W+1:2];

  instr_decode u_decode (
    .ir_i        (ir_q),
    .nzcv_i      (status_nzcv),
    .opcode_o    (opcode),
    .set_flags_o (set_flags),
    .rn_o        (rn),
    .rd_o        (rd),
    .rs_o        (rs),
    .rm_o        (rm),
    .shift_op_o  (shift_op),
    .imm12_o     (imm12),
    .cond_pass_o (cond_pass)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-programmable instruction
// memory responder.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic        load_pc;
  logic        clear_pc;
  logic [31:0] pc_in;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [3:0]  status_nzcv;
  logic [31:0] pc;
  logic        ir_valid;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic        set_flags;
  logic [3:0]  rn, rd, rs, rm;
  logic [1:0]  shift_op;
  logic [31:0] imm12;
  logic        cond_pass;
  logic        halted;
  logic        busy;

  int          total;
  int          bad;

  logic [31:0] mem [0:63];
  int          mem_lat;
  int          lat_cnt;
  logic [5:0]  held_addr;
  int          rd_count;
  int          rvalid_count;
  logic [15:0] rd_addrs [$];

  fetch_unit #(.ADDR_W(16), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .load_pc     (load_pc),
    .clear_pc    (clear_pc),
    .pc_in       (pc_in),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .status_nzcv (status_nzcv),
    .pc          (pc),
    .ir_valid    (ir_valid),
    .ir          (ir),
    .opcode      (opcode),
    .set_flags   (set_flags),
    .rn          (rn),
    .rd          (rd),
    .rs          (rs),
    .rm          (rm),
    .shift_op    (shift_op),
    .imm12       (imm12),
    .cond_pass   (cond_pass),
    .halted      (halted),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory: answers a strobe mem_lat cycles later (0 = same cycle as the strobe).
  initial begin
    mem_rvalid   = 1'b0;
    mem_rdata    = 32'h0;
    lat_cnt      = 0;
    held_addr    = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[held_addr];
          rvalid_count++;
        end
      end
      if (mem_rd_en) begin
        rd_count++;
        rd_addrs.push_back(mem_addr);
        if (mem_lat == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[mem_addr[5:0]];
          rvalid_count++;
        end else begin
          lat_cnt   = mem_lat;
          held_addr = mem_addr[5:0];
        end
      end
    end
  end

  logic [31:0] cond_words [0:5];
  logic [3:0]  nzcv_a     [0:5];
  logic [3:0]  nzcv_b     [0:5];
  logic        exp_a      [0:5];
  logic        exp_b      [0:5];

  initial begin
    int rv0;
    total = 0;
    bad   = 0;
    rd_count     = 0;
    rvalid_count = 0;
    mem_lat      = 0;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'hE200_1005;  // AL MOV_I rd=1 imm=5
    mem[1]  = 32'hE110_2003;  // opcode 0x08, S=1, rd=2, rm=3
    mem[2]  = 32'hDEAD_BEEF;  // only ever fetched by the squashed read
    mem[16] = 32'hE1A3_4CC5;  // opcode 0x0D, rn=3 rd=4 rs=C shift=3 rm=5
    mem[17] = 32'hE020_0000;  // HLT

    cond_words = '{32'h0200_1005, 32'h1200_1005, 32'hA200_1005,
                   32'hB200_1005, 32'hE200_1005, 32'h5200_1005};
    for (int i = 0; i < 6; i++) mem[20+i] = cond_words[i];
    nzcv_a = '{4'b0100, 4'b0100, 4'b1001, 4'b1000, 4'b0000, 4'b1111};
    exp_a  = '{1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b0};
    nzcv_b = '{4'b0000, 4'b0000, 4'b1000, 4'b1001, 4'b1111, 4'b0000};
    exp_b  = '{1'b0,    1'b1,    1'b0,    1'b0,    1'b1,    1'b0};

    rst = 1'b1; fetch_req = 1'b0; load_pc = 1'b0; clear_pc = 1'b0;
    pc_in = 32'h0; status_nzcv = 4'b0000;

    // Reset state
    tick(); tick();
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_ir_valid", ir_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_opcode", opcode, 7'h00);
    check("rst_cond_z0", cond_pass, 1'b0);
    status_nzcv = 4'b0100;
    #1;
    check("rst_cond_z1", cond_pass, 1'b1);
    status_nzcv = 4'b0000;
    rst = 1'b0;
    tick();
    check("post_rst_busy", busy, 1'b0);

    // Zero-wait fetch: strobe at t+1, instruction at t+2
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("f1_rd_en", mem_rd_en, 1'b1);
    check("f1_addr", mem_addr, 16'd0);
    check("f1_busy", busy, 1'b1);
    tick();
    check("f1_ir_valid", ir_valid, 1'b1);
    check("f1_ir", ir, 32'hE200_1005);
    check("f1_opcode", opcode, 7'h10);
    check("f1_rd", rd, 4'd1);
    check("f1_imm12", imm12, 32'd5);
    check("f1_cond", cond_pass, 1'b1);
    check("f1_pc", pc, 32'd4);
    check("f1_rd_en_low", mem_rd_en, 1'b0);

    // Two back-to-back requests with L=3: second one is held and served after
    clear_pc = 1'b1;
    tick();
    clear_pc = 1'b0;
    check("clr_pc", pc, 32'h0);
    mem_lat = 3;
    rd_count = 0;
    rd_addrs.delete();
    fetch_req = 1'b1;
    tick();
    check("f2_rd_en", mem_rd_en, 1'b1);
    check("f2_addr0", mem_addr, 16'd0);
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("f2_irv_vs_busy_%0d", i), ir_valid, !busy);
      tick();
    end
    check("f2_reads", rd_count, 2);
    check("f2_addr_a", rd_addrs.size() > 0 ? rd_addrs[0] : 16'hFFFF, 16'd0);
    check("f2_addr_b", rd_addrs.size() > 1 ? rd_addrs[1] : 16'hFFFF, 16'd1);
    check("f2_pc", pc, 32'd8);
    check("f2_ir", ir, 32'hE110_2003);
    check("f2_opcode", opcode, 7'h08);
    check("f2_set_flags", set_flags, 1'b1);
    check("f2_rm", rm, 4'd3);

    // Redirect during WAIT squashes the in-flight read
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("sq_rd_en", mem_rd_en, 1'b1);
    check("sq_addr", mem_addr, 16'd2);
    tick();
    check("sq_wait_busy", busy, 1'b1);
    rv0 = rvalid_count;
    load_pc = 1'b1;
    pc_in   = 32'h0000_0043;  // low bits must be dropped
    tick();
    load_pc = 1'b0;
    check("sq_pc", pc, 32'h40);
    check("sq_still_busy", busy, 1'b1);
    check("sq_irv_wait", ir_valid, 1'b0);
    tick(); tick();
    check("sq_returned", rvalid_count - rv0, 1);
    check("sq_idle_busy", busy, 1'b0);
    check("sq_irv", ir_valid, 1'b0);
    check("sq_ir_kept", ir, 32'hE110_2003);
    check("sq_pc_kept", pc, 32'h40);
    mem_lat = 0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("sq_next_rd_en", mem_rd_en, 1'b1);
    check("sq_next_addr", mem_addr, 16'd16);
    tick();
    check("sq_next_ir", ir, 32'hE1A3_4CC5);
    check("sq_next_opcode", opcode, 7'h0D);
    check("sq_next_rn", rn, 4'd3);
    check("sq_next_rd", rd, 4'd4);
    check("sq_next_rs", rs, 4'hC);
    check("sq_next_shift", shift_op, 2'd3);
    check("sq_next_rm", rm, 4'd5);
    check("sq_next_imm", imm12, 32'h0000_0CC5);
    check("sq_next_sf", set_flags, 1'b0);
    check("sq_next_pc", pc, 32'h44);

    // HLT stops fetching until clear_pc
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    check("hlt_opcode", opcode, 7'h01);
    check("hlt_halted", halted, 1'b1);
    check("hlt_pc", pc, 32'h48);
    rd_count = 0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick(); tick();
    check("hlt_no_reads", rd_count, 0);
    check("hlt_not_busy", busy, 1'b0);
    clear_pc = 1'b1;
    tick();
    clear_pc = 1'b0;
    check("clr_halted", halted, 1'b0);
    check("clr_pc2", pc, 32'h0);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("resume_rd_en", mem_rd_en, 1'b1);
    check("resume_addr", mem_addr, 16'd0);
    tick();
    check("resume_ir", ir, 32'hE200_1005);
    check("resume_pc", pc, 32'd4);

    // Condition evaluation sweep
    load_pc = 1'b1;
    pc_in   = 32'h50;
    tick();
    load_pc = 1'b0;
    check("cond_pc", pc, 32'h50);
    for (int i = 0; i < 6; i++) begin
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      tick();
      check($sformatf("cond_ir_%0d", i), ir, cond_words[i]);
      status_nzcv = nzcv_a[i];
      #1;
      check($sformatf("cond_a_%0d", i), cond_pass, exp_a[i]);
      status_nzcv = nzcv_b[i];
      #1;
      check($sformatf("cond_b_%0d", i), cond_pass, exp_b[i]);
    end
    status_nzcv = 4'b0000;
    check("cond_end_pc", pc, 32'h68);

    // Reset during WAIT; the late return must be ignored
    mem_lat = 3;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("rw_rd_en", mem_rd_en, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    check("rw_async_busy", busy, 1'b0);
    check("rw_async_pc", pc, 32'h0);
    tick();
    rst = 1'b0;
    rv0 = rvalid_count;
    tick(); tick(); tick();
    check("rw_late_seen", rvalid_count - rv0, 1);
    check("rw_pc", pc, 32'h0);
    check("rw_ir", ir, 32'h0);
    check("rw_ir_valid", ir_valid, 1'b0);
    check("rw_halted", halted, 1'b0);
    check("rw_busy", busy, 1'b0);
    check("rw_rd_en", mem_rd_en, 1'b0);
    check("rw_opcode", opcode, 7'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
